// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - board/CPU-side signal bundle for the run/step controller
interface cpu_run_ctrl_if;
  logic        BTN_STEP;
  logic        SW_RUN;
  logic        BRK_EN;
  logic [31:0] BRK_ADDR;
  logic [31:0] PC;
  logic        CPU_CE;
  logic        HALTED;
  logic [15:0] STEP_CNT;
  logic [1:0]  STATE;

  modport master (
    output BTN_STEP, SW_RUN, BRK_EN, BRK_ADDR, PC,
    input  CPU_CE, HALTED, STEP_CNT, STATE
  );

  modport slave (
    input  BTN_STEP, SW_RUN, BRK_EN, BRK_ADDR, PC,
    output CPU_CE, HALTED, STEP_CNT, STATE
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU clock-enable generator from debounced step, divided free run and PC breakpoint
module cpu_run_ctrl #(
  parameter int DB_MAX  = 100000,
  parameter int DIV_MAX = 10000000
) (
  input  logic          CLK,
  input  logic          RST,
  cpu_run_ctrl_if.slave io
);

  localparam int DB_W  = 17;
  localparam int DIV_W = 24;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_MAX - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  logic             btn_m_q, btn_m_d, btn_s_q, btn_s_d;
  logic             run_m_q, run_m_d, run_s_q, run_s_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_lvl_q, db_lvl_d, db_dly_q, db_dly_d;
  logic             step_pulse_q, step_pulse_d;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpu_ce_q, cpu_ce_d, halted_q, halted_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             run_ce;

  always_comb begin
    btn_m_d      = io.BTN_STEP;
    btn_s_d      = btn_m_q;
    run_m_d      = io.SW_RUN;
    run_s_d      = run_m_q;
    db_lvl_d     = db_lvl_q;
    db_cnt_d     = '0;
    // The level only moves after DB_MAX consecutive disagreeing samples.
    if (btn_s_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    db_dly_d     = db_lvl_q;
    step_pulse_d = db_lvl_q & ~db_dly_q;
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    run_ce  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_s_q) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (step_pulse_q) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run_s_q) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (io.BRK_EN && (io.PC == io.BRK_ADDR)) begin
            state_d = ST_HALT;
          end else begin
            run_ce = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_STEP: state_d = ST_IDLE;
      ST_HALT: begin
        if (!run_s_q) begin
          state_d = ST_IDLE;
        end else if (step_pulse_q) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered, so they are derived from the next state.
    cpu_ce_d   = run_ce | (state_d == ST_STEP);
    halted_d   = (state_d == ST_HALT);
    step_cnt_d = cpu_ce_d ? step_cnt_q + 16'd1 : step_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_m_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      run_m_q      <= 1'b0;
      run_s_q      <= 1'b0;
      db_cnt_q     <= '0;
      db_lvl_q     <= 1'b0;
      db_dly_q     <= 1'b0;
      step_pulse_q <= 1'b0;
      state_q      <= ST_IDLE;
      div_q        <= '0;
      cpu_ce_q     <= 1'b0;
      halted_q     <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      btn_m_q      <= btn_m_d;
      btn_s_q      <= btn_s_d;
      run_m_q      <= run_m_d;
      run_s_q      <= run_s_d;
      db_cnt_q     <= db_cnt_d;
      db_lvl_q     <= db_lvl_d;
      db_dly_q     <= db_dly_d;
      step_pulse_q <= step_pulse_d;
      state_q      <= state_d;
      div_q        <= div_d;
      cpu_ce_q     <= cpu_ce_d;
      halted_q     <= halted_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign io.CPU_CE   = cpu_ce_q;
  assign io.HALTED   = halted_q;
  assign io.STEP_CNT = step_cnt_q;
  assign io.STATE    = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl with a timestamp-based reference model
module tb_cpu_run_ctrl;
  localparam int DB  = 4;
  localparam int DIV = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w_rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if m_if ();
  cpu_run_ctrl_if w_if ();

  cpu_run_ctrl #(.DB_MAX(DB), .DIV_MAX(DIV)) dut (.CLK(clk), .RST(rst), .io(m_if.slave));
  cpu_run_ctrl #(.DB_MAX(DB), .DIV_MAX(1)) dut_w (.CLK(clk), .RST(w_rst), .io(w_if.slave));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ce_seen = 0;
  int w_pulses = 0;

  typedef struct {int cyc; int cnt;} pulse_t;
  pulse_t exp_q[$];

  int m_state = 0, m_cnt = 0, m_entry = 0, m_rise = -100;
  bit m_db = 1'b0;
  bit btn_h[$];
  bit run_h[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_hist();
    btn_h = {};
    run_h = {};
    for (int i = 0; i < DB + 2; i++) begin
      btn_h.push_back(1'b0);
      run_h.push_back(1'b0);
    end
  endtask

  // Debounced level toggles once the last DB synchronized samples all disagree with it.
  function automatic bit db_flip();
    for (int i = 1; i <= DB; i++)
      if (btn_h[btn_h.size() - 1 - i] == m_db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit sp, rs, pulse;
    int ns;
    cyc++;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_db = 1'b0; m_rise = -100;
      clear_hist();
    end else begin
      sp    = (cyc == m_rise + 2);
      rs    = run_h[run_h.size() - 2];
      pulse = 1'b0;
      ns    = m_state;
      case (m_state)
        0: if (rs) begin ns = 1; m_entry = cyc; end else if (sp) ns = 2;
        1: if (!rs) ns = 0;
           else if ((cyc - m_entry) % DIV == 0) begin
             if (m_if.BRK_EN && m_if.PC == m_if.BRK_ADDR) ns = 3; else pulse = 1'b1;
           end
        2: ns = 0;
        default: if (!rs) ns = 0; else if (sp) ns = 2;
      endcase
      if (ns == 2) pulse = 1'b1;
      m_state = ns;
      if (pulse) begin
        m_cnt = (m_cnt + 1) % 65536;
        exp_q.push_back('{cyc: cyc, cnt: m_cnt});
      end
      if (db_flip()) begin
        m_db = ~m_db;
        if (m_db) m_rise = cyc;
      end
      btn_h.push_back(m_if.BTN_STEP);
      run_h.push_back(m_if.SW_RUN);
      void'(btn_h.pop_front());
      void'(run_h.pop_front());
    end
  endtask

  initial begin
    clear_hist();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic exp_ce;
    forever begin
      @(negedge clk);
      chk("state", m_if.STATE, m_state);
      chk("halted", m_if.HALTED, m_state == 3);
      exp_ce = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("cpu_ce", m_if.CPU_CE, exp_ce);
      if (m_if.CPU_CE === 1'b1) ce_seen++;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("ce_step_cnt", m_if.STEP_CNT, exp_q[0].cnt);
        void'(exp_q.pop_front());
      end else begin
        chk("step_cnt", m_if.STEP_CNT, m_cnt);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (w_if.CPU_CE === 1'b1) begin
        w_pulses++;
        if (w_pulses == 1 || w_pulses >= 65535)
          chk("wrap_step_cnt", w_if.STEP_CNT, w_pulses % 65536);
      end
    end
  end

  task automatic main_flow();
    int base;
    m_if.BTN_STEP = 1'b1; m_if.SW_RUN = 1'b1; m_if.BRK_EN = 1'b1;
    m_if.BRK_ADDR = 32'h1; m_if.PC = 32'h1;
    rst = 1'b1;
    tick(3);
    chk("rst_state", m_if.STATE, 2'd0);
    chk("rst_ce", m_if.CPU_CE, 1'b0);
    chk("rst_halted", m_if.HALTED, 1'b0);
    chk("rst_step_cnt", m_if.STEP_CNT, 16'd0);
    rst = 1'b0;
    tick(2);
    chk("release_not_yet_run", m_if.STATE, 2'd0);
    tick(1);
    chk("release_run_at_3", m_if.STATE, 2'd1);
    tick(10);
    chk("release_brk_halt", m_if.STATE, 2'd3);
    m_if.SW_RUN = 1'b0; m_if.BTN_STEP = 1'b0; m_if.BRK_EN = 1'b0;
    m_if.BRK_ADDR = 32'h10; m_if.PC = 32'h0;
    tick(10);
    chk("idle_no_pulses", m_if.STEP_CNT, 16'd0);

    // Glitchy long press, then a short press.
    base = ce_seen;
    m_if.BTN_STEP = 1'b1; tick(2);
    m_if.BTN_STEP = 1'b0; tick(2);
    m_if.BTN_STEP = 1'b1; tick(20);
    m_if.BTN_STEP = 1'b0; tick(20);
    chk("glitch_press_pulses", ce_seen - base, 1);
    chk("glitch_press_cnt", m_if.STEP_CNT, 16'd1);
    chk("glitch_press_state", m_if.STATE, 2'd0);
    base = ce_seen;
    m_if.BTN_STEP = 1'b1; tick(3);
    m_if.BTN_STEP = 1'b0; tick(15);
    chk("short_press_pulses", ce_seen - base, 0);

    // Free run; the drop of SW_RUN lands on a due pulse.
    base = ce_seen;
    m_if.SW_RUN = 1'b1; tick(3);
    chk("free_run_entry", m_if.STATE, 2'd1);
    tick(32);
    m_if.SW_RUN = 1'b0; tick(5);
    chk("free_run_pulses", ce_seen - base, 6);
    chk("free_run_exit", m_if.STATE, 2'd0);
    chk("free_run_cnt", m_if.STEP_CNT, 16'd7);

    // Breakpoint, then step past it.
    base = ce_seen;
    m_if.BRK_EN = 1'b1; m_if.BRK_ADDR = 32'h10; m_if.PC = 32'h10;
    m_if.SW_RUN = 1'b1; tick(3);
    chk("brk_run_entry", m_if.STATE, 2'd1);
    tick(5);
    chk("brk_halt_state", m_if.STATE, 2'd3);
    chk("brk_halted", m_if.HALTED, 1'b1);
    chk("brk_no_pulse", ce_seen - base, 0);
    m_if.PC = 32'h14;
    m_if.BTN_STEP = 1'b1; tick(12);
    chk("brk_step_pulses", ce_seen - base, 1);
    chk("brk_back_to_run", m_if.STATE, 2'd1);
    m_if.BTN_STEP = 1'b0; m_if.SW_RUN = 1'b0; tick(8);
    m_if.BRK_EN = 1'b0;

    // step_pulse and run_s reach IDLE on the same edge.
    m_if.BTN_STEP = 1'b1; tick(5);
    base = ce_seen;
    m_if.SW_RUN = 1'b1; tick(6);
    chk("prio_run_state", m_if.STATE, 2'd1);
    chk("prio_no_step", ce_seen - base, 0);
    m_if.SW_RUN = 1'b0; m_if.BTN_STEP = 1'b0; tick(10);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: m_if.BTN_STEP = ~m_if.BTN_STEP;
        4, 5:       m_if.SW_RUN = ~m_if.SW_RUN;
        6, 7: begin
          m_if.BRK_EN = 1'($urandom_range(0, 1));
          m_if.PC = ($urandom_range(0, 1) == 1) ? 32'h10 : 32'h14;
        end
        8: if ($urandom_range(0, 3) == 0) begin
          rst = 1'b1; tick($urandom_range(1, 2)); rst = 1'b0;
        end
        default: ;
      endcase
      tick($urandom_range(1, 8));
    end
    m_if.SW_RUN = 1'b0; m_if.BTN_STEP = 1'b0; tick(10);
    chk("final_idle", m_if.STATE, 2'd0);
  endtask

  task automatic wrap_flow();
    w_if.BTN_STEP = 1'b0; w_if.SW_RUN = 1'b0; w_if.BRK_EN = 1'b0;
    w_if.BRK_ADDR = 32'h0; w_if.PC = 32'h0;
    w_rst = 1'b1;
    tick(3);
    w_rst = 1'b0;
    w_if.SW_RUN = 1'b1;
    wait (w_pulses >= 65537);
    #1;
    w_if.SW_RUN = 1'b0;
    tick(5);
    chk("wrap_total_pulses", w_pulses, 65539);
    chk("wrap_final_cnt", w_if.STEP_CNT, 16'd3);
    chk("wrap_final_state", w_if.STATE, 2'd0);
  endtask

  initial begin
    fork
      main_flow();
      wrap_flow();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    n_chk++;
    n_fail++;
    $display("FAIL timeout: got cycle %0d required completion before 90000", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
